// File: rtl/idi_pkt_tracker.sv
// Per-virtual-channel packet/frame tracker for the CSI-2 IDI bus.
// Measures long-packet payload bytes against the header word count,
// tracks FS/FE frame state and reports line/frame counts and sticky
// errors per VC. Purely observational: never stalls the bus.
module idi_pkt_tracker #(
  parameter int DATA_W      = 64,
  parameter int BYTE_EN_W   = $clog2(DATA_W / 8),
  parameter int N_VC        = 16,
  parameter int VC_W        = 4,
  parameter int LINE_CNT_W  = 16,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                          clk_data,
  input  logic                          rst,
  input  logic                          header_en,
  input  logic                          data_en,
  input  logic [BYTE_EN_W-1:0]          byte_en,
  input  logic [5:0]                    data_type,
  input  logic [15:0]                   word_count,
  input  logic [VC_W-1:0]               virtual_channel,
  input  logic                          clr_err,
  output logic                          pkt_done,
  output logic                          pkt_len_err,
  output logic [VC_W-1:0]               pkt_vc,
  output logic [15:0]                   pkt_byte_cnt,
  output logic [N_VC-1:0]               frame_active,
  output logic [N_VC-1:0]               len_err_sticky,
  output logic [N_VC-1:0]               frame_err_sticky,
  output logic [N_VC*LINE_CNT_W-1:0]    line_cnt_flat,
  output logic [N_VC*FRAME_CNT_W-1:0]   frame_cnt_flat
);

  typedef enum logic {IDLE = 1'b0, PAYLOAD = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic [VC_W-1:0] vc_reg, vc_next;
  logic [15:0]     wc_reg, wc_next;
  logic [15:0]     byte_cnt_reg, byte_cnt_next;
  logic            beat_reg, beat_next;
  logic [16:0]     byte_sum;

  logic hdr_long, hdr_fs, hdr_fe;
  logic close, len_mis;

  logic            pkt_done_reg, pkt_len_err_reg;
  logic [VC_W-1:0] pkt_vc_reg;
  logic [15:0]     pkt_byte_cnt_reg;

  // Header decode and close detection (abort on header, or end of beats).
  always_comb begin
    hdr_long = header_en && (data_type >= 6'h10);
    hdr_fs   = header_en && (data_type == 6'h00);
    hdr_fe   = header_en && (data_type == 6'h01);
    close    = (state_reg == PAYLOAD) && (header_en || (!data_en && beat_reg));
    len_mis  = (byte_cnt_reg != wc_reg);
    byte_sum = {1'b0, byte_cnt_reg} + {{(17-BYTE_EN_W){1'b0}}, byte_en} + 17'd1;
  end

  // Packet FSM state register and latched packet context.
  always_ff @(posedge clk_data) begin
    if (rst) begin
      state_reg    <= IDLE;
      vc_reg       <= '0;
      wc_reg       <= '0;
      byte_cnt_reg <= '0;
      beat_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      vc_reg       <= vc_next;
      wc_reg       <= wc_next;
      byte_cnt_reg <= byte_cnt_next;
      beat_reg     <= beat_next;
    end
  end

  // Next-state: any header restarts the FSM (long -> new packet, short -> IDLE),
  // so a header that aborts a packet is still taken in the same cycle.
  always_comb begin
    state_next    = state_reg;
    vc_next       = vc_reg;
    wc_next       = wc_reg;
    byte_cnt_next = byte_cnt_reg;
    beat_next     = beat_reg;
    if (header_en) begin
      if (hdr_long) begin
        state_next    = PAYLOAD;
        vc_next       = virtual_channel;
        wc_next       = word_count;
        byte_cnt_next = '0;
        beat_next     = 1'b0;
      end else begin
        state_next = IDLE;
      end
    end else if (state_reg == PAYLOAD) begin
      if (data_en) begin
        byte_cnt_next = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];
        beat_next     = 1'b1;
      end else if (beat_reg) begin
        state_next = IDLE;
      end
    end
  end

  // Registered packet-close report; vc/count hold between closes.
  always_ff @(posedge clk_data) begin
    if (rst) begin
      pkt_done_reg     <= 1'b0;
      pkt_len_err_reg  <= 1'b0;
      pkt_vc_reg       <= '0;
      pkt_byte_cnt_reg <= '0;
    end else begin
      pkt_done_reg    <= close;
      pkt_len_err_reg <= close && len_mis;
      if (close) begin
        pkt_vc_reg       <= vc_reg;
        pkt_byte_cnt_reg <= byte_cnt_reg;
      end
    end
  end

  assign pkt_done     = pkt_done_reg;
  assign pkt_len_err  = pkt_len_err_reg;
  assign pkt_vc       = pkt_vc_reg;
  assign pkt_byte_cnt = pkt_byte_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_VC; gi++) begin : g_vc
      logic                   close_hit, hdr_hit;
      logic                   fa_reg, fa_next;
      logic                   lerr_reg, ferr_reg, lerr_set, ferr_set;
      logic [LINE_CNT_W-1:0]  run_reg, run_next, line_reg, line_next;
      logic [FRAME_CNT_W-1:0] fcnt_reg, fcnt_next;

      // Per-VC accounting: the closing packet is counted before a same-cycle
      // FS/FE so a line that ends on the FE header still lands in the frame.
      always_comb begin
        close_hit = close && (vc_reg == VC_W'(gi));
        hdr_hit   = header_en && (virtual_channel == VC_W'(gi));
        run_next  = run_reg;
        line_next = line_reg;
        fcnt_next = fcnt_reg;
        fa_next   = fa_reg;
        lerr_set  = close_hit && len_mis;
        ferr_set  = 1'b0;
        if (close_hit) begin
          if (fa_reg) run_next = (run_reg == '1) ? run_reg : run_reg + 1'b1;
          else        ferr_set = 1'b1;
        end
        if (hdr_hit && hdr_fs) begin
          if (fa_reg) ferr_set = 1'b1;
          fa_next  = 1'b1;
          run_next = '0;
        end else if (hdr_hit && hdr_fe) begin
          if (!fa_reg) begin
            ferr_set = 1'b1;
          end else begin
            line_next = run_next;
            fcnt_next = fcnt_reg + 1'b1;
            fa_next   = 1'b0;
          end
        end
      end

      // Per-VC state; a newly detected error beats a same-cycle clear.
      always_ff @(posedge clk_data) begin
        if (rst) begin
          fa_reg   <= 1'b0;
          run_reg  <= '0;
          line_reg <= '0;
          fcnt_reg <= '0;
          lerr_reg <= 1'b0;
          ferr_reg <= 1'b0;
        end else begin
          fa_reg   <= fa_next;
          run_reg  <= run_next;
          line_reg <= line_next;
          fcnt_reg <= fcnt_next;
          lerr_reg <= lerr_set | (lerr_reg & ~clr_err);
          ferr_reg <= ferr_set | (ferr_reg & ~clr_err);
        end
      end

      assign frame_active[gi]                              = fa_reg;
      assign len_err_sticky[gi]                            = lerr_reg;
      assign frame_err_sticky[gi]                          = ferr_reg;
      assign line_cnt_flat[gi*LINE_CNT_W +: LINE_CNT_W]    = line_reg;
      assign frame_cnt_flat[gi*FRAME_CNT_W +: FRAME_CNT_W] = fcnt_reg;
    end
  endgenerate

endmodule

// File: tb/tb_idi_pkt_tracker.sv
// Directed self-checking bench for idi_pkt_tracker.
module tb_idi_pkt_tracker;

  logic         clk_data = 1'b0;
  logic         rst = 1'b1;
  logic         header_en = 1'b0;
  logic         data_en = 1'b0;
  logic [2:0]   byte_en = '0;
  logic [5:0]   data_type = '0;
  logic [15:0]  word_count = '0;
  logic [3:0]   virtual_channel = '0;
  logic         clr_err = 1'b0;
  logic         pkt_done, pkt_len_err;
  logic [3:0]   pkt_vc;
  logic [15:0]  pkt_byte_cnt;
  logic [15:0]  frame_active, len_err_sticky, frame_err_sticky;
  logic [255:0] line_cnt_flat, frame_cnt_flat;

  int tests = 0;
  int fails = 0;

  idi_pkt_tracker dut (
    .clk_data(clk_data), .rst(rst), .header_en(header_en), .data_en(data_en),
    .byte_en(byte_en), .data_type(data_type), .word_count(word_count),
    .virtual_channel(virtual_channel), .clr_err(clr_err), .pkt_done(pkt_done),
    .pkt_len_err(pkt_len_err), .pkt_vc(pkt_vc), .pkt_byte_cnt(pkt_byte_cnt),
    .frame_active(frame_active), .len_err_sticky(len_err_sticky),
    .frame_err_sticky(frame_err_sticky), .line_cnt_flat(line_cnt_flat),
    .frame_cnt_flat(frame_cnt_flat)
  );

  always #5 clk_data = ~clk_data;

  task automatic tick();
    @(posedge clk_data);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hdr(input logic [5:0] dt, input logic [15:0] wc, input logic [3:0] vc);
    header_en = 1'b1; data_type = dt; word_count = wc; virtual_channel = vc;
    tick();
    header_en = 1'b0;
  endtask

  task automatic beat(input logic [2:0] be);
    data_en = 1'b1; byte_en = be;
    tick();
    data_en = 1'b0;
  endtask

  task automatic clear();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  function automatic logic [15:0] line_of(input int v);
    return line_cnt_flat[v*16 +: 16];
  endfunction

  function automatic logic [15:0] frames_of(input int v);
    return frame_cnt_flat[v*16 +: 16];
  endfunction

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_byte_cnt", pkt_byte_cnt, 0);
    chk("rst_frame_active", frame_active, 0);
    chk("rst_frame_cnt", frame_cnt_flat[31:0], 0);
    rst = 1'b0;
    tick();

    // Correct long packet on VC2, outside any frame
    hdr(6'h2A, 16'd24, 4'd2);
    beat(3'd7); beat(3'd7); beat(3'd7);
    chk("t1_not_yet_done", pkt_done, 0);
    tick();
    chk("t1_done", pkt_done, 1);
    chk("t1_bytes", pkt_byte_cnt, 24);
    chk("t1_len_err", pkt_len_err, 0);
    chk("t1_vc", pkt_vc, 2);
    chk("t1_frame_err_no_fs", frame_err_sticky, 16'h0004);
    tick();
    chk("t1_done_pulse", pkt_done, 0);
    clear();

    // Short last beat -> length error
    hdr(6'h2A, 16'd24, 4'd2);
    beat(3'd7); beat(3'd7); beat(3'd3);
    tick();
    chk("t2_done", pkt_done, 1);
    chk("t2_bytes", pkt_byte_cnt, 20);
    chk("t2_len_err", pkt_len_err, 1);
    chk("t2_sticky", len_err_sticky, 16'h0004);
    clear();
    chk("t2_sticky_clr", len_err_sticky, 0);
    chk("t2_ferr_clr", frame_err_sticky, 0);

    // Frame on VC5 with four lines
    hdr(6'h00, 16'd0, 4'd5);
    chk("t3_fs_active", frame_active, 16'h0020);
    for (int i = 0; i < 4; i++) begin
      hdr(6'h2B, 16'd8, 4'd5);
      beat(3'd7);
      tick();
    end
    hdr(6'h01, 16'd0, 4'd5);
    chk("t3_line_cnt", line_of(5), 4);
    chk("t3_frame_cnt", frames_of(5), 1);
    chk("t3_fe_inactive", frame_active, 0);
    chk("t3_no_ferr", frame_err_sticky, 0);
    chk("t3_no_lerr", len_err_sticky, 0);

    // Framing errors
    hdr(6'h01, 16'd0, 4'd1);
    chk("t4_fe_no_fs", frame_err_sticky, 16'h0002);
    chk("t4_fe_no_count", frames_of(1), 0);
    clear();
    hdr(6'h00, 16'd0, 4'd3);
    hdr(6'h00, 16'd0, 4'd3);
    chk("t4_fs_fs_err", frame_err_sticky, 16'h0008);
    chk("t4_fs_fs_active", frame_active, 16'h0008);
    clear();

    // Header right after a long header: zero-byte close, second header kept
    hdr(6'h2A, 16'd24, 4'd3);
    hdr(6'h2A, 16'd8, 4'd3);
    chk("t5_abort_done", pkt_done, 1);
    chk("t5_abort_bytes", pkt_byte_cnt, 0);
    chk("t5_abort_len_err", pkt_len_err, 1);
    beat(3'd7);
    tick();
    chk("t5_second_done", pkt_done, 1);
    chk("t5_second_bytes", pkt_byte_cnt, 8);
    chk("t5_second_len_err", pkt_len_err, 0);
    hdr(6'h01, 16'd0, 4'd3);
    chk("t5_line_cnt", line_of(3), 2);
    chk("t5_frame_cnt", frames_of(3), 1);
    chk("t5_lerr_sticky", len_err_sticky, 16'h0008);
    clear();

    // Header and data together: header wins, beat dropped; FE closes the line
    hdr(6'h00, 16'd0, 4'd6);
    hdr(6'h2A, 16'd16, 4'd6);
    beat(3'd7);
    data_en = 1'b1; byte_en = 3'd7;
    hdr(6'h01, 16'd0, 4'd6);
    data_en = 1'b0;
    chk("t6_done", pkt_done, 1);
    chk("t6_bytes", pkt_byte_cnt, 8);
    chk("t6_line_cnt", line_of(6), 1);
    chk("t6_frame_cnt", frames_of(6), 1);
    chk("t6_inactive", frame_active, 0);

    // Reset in mid-payload inside an active frame
    hdr(6'h00, 16'd0, 4'd7);
    hdr(6'h2A, 16'd16, 4'd7);
    beat(3'd7);
    rst = 1'b1;
    tick();
    chk("t7_rst_done", pkt_done, 0);
    chk("t7_rst_active", frame_active, 0);
    chk("t7_rst_frames", frame_cnt_flat[127:96], 0);
    chk("t7_rst_lines", line_cnt_flat[111:96], 0);
    chk("t7_rst_bytes", pkt_byte_cnt, 0);
    rst = 1'b0;
    tick();
    chk("t7_idle_no_done", pkt_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
